// File: rtl/data_pack_pkg.sv
// Shared types and helpers for the data_pack byte repacker.
package data_pack_pkg;

  localparam int BYTES_DEF = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Number of consecutive ones starting at bit 0; bits past the first zero are ignored.
  function automatic int keep_to_cnt(input logic [31:0] keep);
    int  n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (run && keep[i]) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] cnt_to_keep(input int cnt);
    logic [31:0] k;
    k = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < cnt) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/data_pack_keep_decode.sv
// Turns a byte-valid mask into a contiguous byte count plus a non-contiguity flag.
module data_pack_keep_decode
  import data_pack_pkg::*;
#(
  parameter  int BYTES = BYTES_DEF,
  localparam int KW    = $clog2(BYTES + 1)
) (
  input  logic [BYTES-1:0] i_keep,
  output logic [KW-1:0]    o_cnt,
  output logic             o_err
);

  logic [31:0] w_keep32;
  int          w_cnt;

  assign w_keep32 = 32'(i_keep);
  assign w_cnt    = keep_to_cnt(w_keep32);
  assign o_cnt    = KW'(w_cnt);
  assign o_err    = (w_keep32 != cnt_to_keep(w_cnt));

endmodule

// File: rtl/data_pack.sv
// Repacks right-aligned partial words into full words, keeping frame boundaries,
// with a single-entry registered output stage.
module data_pack
  import data_pack_pkg::*;
#(
  parameter  int BYTES  = BYTES_DEF,
  localparam int DATA_W = 8 * BYTES
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [BYTES-1:0]  s_tkeep,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [BYTES-1:0]  m_tkeep,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              err_keep
);

  localparam int CNTW = $clog2(BYTES);
  localparam int KW   = $clog2(BYTES + 1);
  localparam int TW   = $clog2(2 * BYTES);
  localparam int RW   = 8 * (BYTES - 1);

  state_t            r_state;
  logic [RW-1:0]     r_res;
  logic [CNTW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_mData;
  logic [BYTES-1:0]  r_mKeep;
  logic              r_mLast;
  logic              r_mValid;
  logic              r_errKeep;

  logic [KW-1:0]        w_k;
  logic                 w_keepErr;
  logic                 w_slotFree;
  logic                 w_accept;
  logic [BYTES-1:0]     w_kKeep;
  logic [DATA_W-1:0]    w_inMasked;
  logic [TW-1:0]        w_total;
  logic [DATA_W+RW-1:0] w_comb;
  logic                 w_full;

  data_pack_keep_decode #(.BYTES(BYTES)) u_keepDecode (
    .i_keep (s_tkeep),
    .o_cnt  (w_k),
    .o_err  (w_keepErr)
  );

  assign w_slotFree = !r_mValid || m_tready;
  assign s_tready   = aresetn && (r_state == RUN) && w_slotFree;
  assign w_accept   = s_tvalid && s_tready;

  // Only the first k input bytes count, even when the mask has stray upper bits.
  assign w_kKeep = BYTES'(cnt_to_keep(int'(w_k)));
  for (genvar g = 0; g < BYTES; g++) begin : g_mask
    assign w_inMasked[8*g +: 8] = s_tdata[8*g +: 8] & {8{w_kKeep[g]}};
  end

  // Residual bytes above r_cnt are always zero, so OR-merging is safe.
  assign w_total = TW'(r_cnt) + TW'(w_k);
  assign w_comb  = {{DATA_W{1'b0}}, r_res} | ({{RW{1'b0}}, w_inMasked} << {r_cnt, 3'b000});
  assign w_full  = (w_total >= TW'(BYTES));

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state   <= RUN;
      r_res     <= '0;
      r_cnt     <= '0;
      r_mData   <= '0;
      r_mKeep   <= '0;
      r_mLast   <= 1'b0;
      r_mValid  <= 1'b0;
      r_errKeep <= 1'b0;
    end else begin
      r_errKeep <= w_accept && w_keepErr;
      if (w_slotFree) begin
        r_mValid <= 1'b0;
        r_mData  <= '0;
        r_mKeep  <= '0;
        r_mLast  <= 1'b0;
        if (r_state == FLUSH) begin
          r_mValid <= 1'b1;
          r_mData  <= {8'h00, r_res};
          r_mKeep  <= BYTES'(cnt_to_keep(int'(r_cnt)));
          r_mLast  <= 1'b1;
          r_res    <= '0;
          r_cnt    <= '0;
          r_state  <= RUN;
        end else if (w_accept) begin
          if (w_full) begin
            r_mValid <= 1'b1;
            r_mData  <= w_comb[DATA_W-1:0];
            r_mKeep  <= '1;
            r_mLast  <= s_tlast && (w_total == TW'(BYTES));
            r_res    <= w_comb[DATA_W +: RW];
            r_cnt    <= CNTW'(w_total - TW'(BYTES));
            if (s_tlast && (w_total != TW'(BYTES))) r_state <= FLUSH;
          end else if (s_tlast) begin
            r_mValid <= 1'b1;
            r_mData  <= w_comb[DATA_W-1:0];
            r_mKeep  <= BYTES'(cnt_to_keep(int'(w_total)));
            r_mLast  <= 1'b1;
            r_res    <= '0;
            r_cnt    <= '0;
          end else begin
            r_res <= w_comb[RW-1:0];
            r_cnt <= CNTW'(w_total);
          end
        end
      end
    end
  end

  assign m_tdata  = r_mData;
  assign m_tkeep  = r_mKeep;
  assign m_tlast  = r_mLast;
  assign m_tvalid = r_mValid;
  assign err_keep = r_errKeep;

endmodule

// File: tb/tb_data_pack.sv
// Directed scenario bench for data_pack (BYTES=4); inputs change and outputs are sampled on the falling edge.
module tb_data_pack;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        err_keep;

  int total = 0;
  int bad   = 0;

  data_pack #(.BYTES(4)) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .err_keep (err_keep)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic l, input logic v);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = v;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    m_tready = 1'b1;
    applyStimulus(32'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata, err_keep} !== 39'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got v=%b l=%b k=%h d=%h e=%b want all zero", m_tvalid, m_tlast, m_tkeep, m_tdata, err_keep);
    end
    total++;
    if (s_tready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b want 0", s_tready);
    end
    aresetn = 1'b1;
    #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL release_ready: got %b want 1", s_tready);
    end
  endtask

  task automatic test_full_word();
    logic [31:0] d [3];
    d[0] = 32'h11111111;
    d[1] = 32'h22222222;
    d[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(d[i], 4'hF, (i == 2), 1'b1);
      #1;
      total++;
      if (s_tready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL full_ready beat%0d: got %b want 1", i, s_tready);
      end
      @(negedge clk);
      total++;
      if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, (i == 2), 4'hF, d[i]}) begin
        bad++;
        $display("[TB] FAIL full_word out%0d: got v=%b l=%b k=%h d=%h want v=1 l=%0d k=f d=%h", i, m_tvalid, m_tlast, m_tkeep, m_tdata, (i == 2), d[i]);
      end
    end
    applyStimulus(32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_idle: got v=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_merge();
    applyStimulus(32'h9999BBAA, 4'h3, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL merge_hold: got v=%b want 0", m_tvalid);
    end
    applyStimulus(32'h77EEDDCC, 4'h7, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b0, 4'hF, 32'hDDCCBBAA}) begin
      bad++;
      $display("[TB] FAIL merge_w0: got v=%b l=%b k=%h d=%h want v=1 l=0 k=f d=ddccbbaa", m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    applyStimulus(32'h662211FF, 4'h7, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b1, 4'hF, 32'h2211FFEE}) begin
      bad++;
      $display("[TB] FAIL merge_w1: got v=%b l=%b k=%h d=%h want v=1 l=1 k=f d=2211ffee", m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    applyStimulus(32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL merge_idle: got v=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_flush();
    applyStimulus(32'hAA030201, 4'h7, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(32'h07060504, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b0, 4'hF, 32'h04030201}) begin
      bad++;
      $display("[TB] FAIL flush_w0: got v=%b l=%b k=%h d=%h want v=1 l=0 k=f d=04030201", m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    applyStimulus(32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    #1;
    total++;
    if (s_tready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_bubble: got s_tready=%b want 0", s_tready);
    end
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b1, 4'h7, 32'h00070605}) begin
      bad++;
      $display("[TB] FAIL flush_w1: got v=%b l=%b k=%h d=%h want v=1 l=1 k=7 d=00070605", m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush_resume: got s_tready=%b want 1", s_tready);
    end
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b1, 4'hF, 32'hDEADBEEF}) begin
      bad++;
      $display("[TB] FAIL flush_next: got v=%b l=%b k=%h d=%h want v=1 l=1 k=f d=deadbeef", m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    applyStimulus(32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    m_tready = 1'b0;
    applyStimulus(32'h55667788, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(32'h0A0B0C0D, 4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({m_tvalid, m_tlast, m_tkeep, m_tdata, s_tready} !== {1'b1, 1'b1, 4'hF, 32'h55667788, 1'b0}) begin
        bad++;
        $display("[TB] FAIL bp_stall%0d: got v=%b l=%b k=%h d=%h rdy=%b want v=1 l=1 k=f d=55667788 rdy=0", i, m_tvalid, m_tlast, m_tkeep, m_tdata, s_tready);
      end
      @(negedge clk);
    end
    m_tready = 1'b1;
    #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_release: got s_tready=%b want 1", s_tready);
    end
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b1, 4'hF, 32'h0A0B0C0D}) begin
      bad++;
      $display("[TB] FAIL bp_next: got v=%b l=%b k=%h d=%h want v=1 l=1 k=f d=0a0b0c0d", m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    applyStimulus(32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_idle: got v=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_keep_err();
    applyStimulus(32'h44332211, 4'h5, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if ({err_keep, m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b1, 1'b1, 4'h1, 32'h00000011}) begin
      bad++;
      $display("[TB] FAIL keep_err: got e=%b v=%b l=%b k=%h d=%h want e=1 v=1 l=1 k=1 d=00000011", err_keep, m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    applyStimulus(32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if ({err_keep, m_tvalid} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL keep_err_pulse: got e=%b v=%b want e=0 v=0", err_keep, m_tvalid);
    end
  endtask

  task automatic test_reset_midframe();
    applyStimulus(32'h1234BEEF, 4'h3, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(32'h0, 4'h0, 1'b0, 1'b0);
    aresetn = 1'b0;
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata, err_keep, s_tready} !== 40'h0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got v=%b l=%b k=%h d=%h e=%b rdy=%b want all zero", m_tvalid, m_tlast, m_tkeep, m_tdata, err_keep, s_tready);
    end
    aresetn = 1'b1;
    applyStimulus(32'h01020304, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b0, 4'hF, 32'h01020304}) begin
      bad++;
      $display("[TB] FAIL midreset_w0: got v=%b l=%b k=%h d=%h want v=1 l=0 k=f d=01020304", m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    applyStimulus(32'h05060708, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b1, 4'hF, 32'h05060708}) begin
      bad++;
      $display("[TB] FAIL midreset_w1: got v=%b l=%b k=%h d=%h want v=1 l=1 k=f d=05060708", m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    applyStimulus(32'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (m_tvalid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midreset_extra%0d: got v=%b d=%h want v=0", i, m_tvalid, m_tdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_merge();
    test_flush();
    test_backpressure();
    test_keep_err();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
